alu_share_arbiter: RTL

Two-requester arbiter and sequencer that time-shares the single pipelined-CPU ALU between the execute stage (requester 0) and an auxiliary unit such as a debug or multi-cycle helper (requester 1). It latches the winning requester's operands, drives the combinational ALU for one cycle, and returns the registered result and zero flag to that requester with a one-cycle done pulse. It counts completed operations. ALU control codes pass through uninterpreted.

---
 rtl/alu_share_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two requesters: IDLE grants and latches operands, ISSUE drives the ALU and captures its result.
// Optional macro ALU_ARB_RR_EN: round-robin tie-break (default build is fixed priority, requester 0 wins ties).
`timescale 1ns/1ps
module alu_share_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_i,
  input  logic [31:0]      src10_i,
  input  logic [31:0]      src20_i,
  input  logic [4:0]       shamt0_i,
  input  logic [3:0]       ctrl0_i,
  output logic             gnt0_o,
  output logic             done0_o,
  output logic [31:0]      result0_o,
  output logic             zero0_o,
  input  logic             req1_i,
  input  logic [31:0]      src11_i,
  input  logic [31:0]      src21_i,
  input  logic [4:0]       shamt1_i,
  input  logic [3:0]       ctrl1_i,
  output logic             gnt1_o,
  output logic             done1_o,
  output logic [31:0]      result1_o,
  output logic             zero1_o,
  output logic [31:0]      alu_src1_o,
  output logic [31:0]      alu_src2_o,
  output logic [4:0]       alu_shamt_o,
  output logic [3:0]       alu_ctrl_o,
  input  logic [31:0]      alu_result_i,
  input  logic             alu_zero_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] op_cnt_o
);

  // Handshake: a requester holds reqN_i with stable operands until it sees
  // gntN_o (one cycle); doneN_o pulses one cycle when resultN_o/zeroN_o update.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_owner;
  logic [31:0]      r_src1;
  logic [31:0]      r_src2;
  logic [4:0]       r_shamt;
  logic [3:0]       r_ctrl;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic [31:0]      r_result0;
  logic [31:0]      r_result1;
  logic             r_zero0;
  logic             r_zero1;
  logic [CNT_W-1:0] r_op_cnt;

  logic             w_any_req;
  logic             w_win1;
  logic             w_issue;

  assign w_any_req = req0_i | req1_i;

`ifdef ALU_ARB_RR_EN
  logic r_last_gnt;
  // On a tie the requester that was not granted last time wins.
  assign w_win1 = req1_i & (~req0_i | ~r_last_gnt);
`else
  assign w_win1 = req1_i & ~req0_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_src1    <= '0;
      r_src2    <= '0;
      r_shamt   <= '0;
      r_ctrl    <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_result0 <= '0;
      r_result1 <= '0;
      r_zero0   <= 1'b0;
      r_zero1   <= 1'b0;
      r_op_cnt  <= '0;
`ifdef ALU_ARB_RR_EN
      r_last_gnt <= 1'b1;
`endif
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_win1;
            r_src1  <= w_win1 ? src11_i  : src10_i;
            r_src2  <= w_win1 ? src21_i  : src20_i;
            r_shamt <= w_win1 ? shamt1_i : shamt0_i;
            r_ctrl  <= w_win1 ? ctrl1_i  : ctrl0_i;
            r_gnt0  <= ~w_win1;
            r_gnt1  <= w_win1;
            r_state <= S_ISSUE;
`ifdef ALU_ARB_RR_EN
            r_last_gnt <= w_win1;
`endif
          end
        end
        S_ISSUE: begin
          // Only the owner's result bank is written; the other keeps its value.
          if (r_owner) begin
            r_result1 <= alu_result_i;
            r_zero1   <= alu_zero_i;
            r_done1   <= 1'b1;
          end else begin
            r_result0 <= alu_result_i;
            r_zero0   <= alu_zero_i;
            r_done0   <= 1'b1;
          end
          r_op_cnt <= r_op_cnt + CNT_ONE;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_issue = (r_state == S_ISSUE);

  // The ALU only ever sees latched operands, and sees zeros (ADD 0+0) when idle.
  assign alu_src1_o  = w_issue ? r_src1  : 32'd0;
  assign alu_src2_o  = w_issue ? r_src2  : 32'd0;
  assign alu_shamt_o = w_issue ? r_shamt : 5'd0;
  assign alu_ctrl_o  = w_issue ? r_ctrl  : 4'd0;

  assign busy_o    = w_issue;
  assign gnt0_o    = r_gnt0;
  assign gnt1_o    = r_gnt1;
  assign done0_o   = r_done0;
  assign done1_o   = r_done1;
  assign result0_o = r_result0;
  assign result1_o = r_result1;
  assign zero0_o   = r_zero0;
  assign zero1_o   = r_zero1;
  assign op_cnt_o  = r_op_cnt;

endmodule
